ram_sd_speicherer: RTL
======================

# ram_sd_speicherer

RAM-to-SD-card dump engine: the write-direction counterpart of the boot loader that copies an SD image into RAM. On a start pulse it reads a run of words from the main RAM and writes them, preceded by a length header, to consecutive SD-card word addresses through the SD writer's word-level handshake. The image layout is identical to what the loader consumes, so a dumped region can be reloaded unchanged. It sits beside the CPU and RAM and owns the RAM address port only while `Busy` is high.

## Interface
- `ADDR_WIDTH`, 16, RAM word-address width.
- `WORDSIZE`, 32, RAM/SD data word width.
- `Clock`  in  1  system clock; all logic on the rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Start`  in  1  one-cycle request; sampled only in IDLE.
- `StartAdresse`  in  ADDR_WIDTH  first RAM word to dump.
- `Anzahl`  in  32  number of data words N.
- `SDZielAdresse`  in  32  SD word address of the header.
- `RAMAdresse`  out  ADDR_WIDTH  RAM read address, registered.
- `RAMDatenRein`  in  WORDSIZE  RAM read data, valid one cycle after `RAMAdresse`.
- `SDAdresse`  out  32  SD target word address, registered.
- `SDDaten`  out  WORDSIZE  SD write data, registered.
- `SDSchreiben`  out  1  one-cycle write strobe.
- `SDBusy`  in  1  SD writer busy; the writer asserts it in the cycle after it samples `SDSchreiben`.
- `Busy`  out  1  dump in progress.
- `Fertig`  out  1  one-cycle completion pulse.

## Operation
- Reset: state IDLE; `RAMAdresse`, `SDAdresse`, `SDDaten`, `SDSchreiben`, `Busy` and `Fertig` all 0; counters cleared.
- Image layout: SD word `SDZielAdresse` holds N-1. The N data words follow at `SDZielAdresse+1` through `SDZielAdresse+N`.
- IDLE: if `Start` is high and N≠0, latch the inputs, set the remaining count to N and go to KOPF. If `Start` is high and N=0, pulse `Fertig` and stay in IDLE; there are no SD writes.
- KOPF: wait for `SDBusy`=0. Then drive `SDDaten`=N-1 and `SDAdresse`=`SDZielAdresse`, strobe, and go to BLIND.
- BLIND: one cycle in which `SDBusy` is ignored. Always go to SDWARTEN.
- SDWARTEN: wait for `SDBusy`=0. If the remaining count is 0, go to ENDE; otherwise go to RAMLESEN.
- RAMLESEN: `RAMAdresse` already holds the current word address. Go to RAMDATEN.
- RAMDATEN: register `RAMDatenRein` into `SDDaten`. Go to SCHREIBEN.
- SCHREIBEN: wait for `SDBusy`=0, then strobe with `SDAdresse`+1. Also increment `RAMAdresse` and decrement the remaining count. Go to BLIND.
- ENDE: `Fertig` high for one cycle, then go to IDLE.
- `Busy` is high in every state except IDLE.
- `Start` asserted while `Busy` is high is ignored, not queued.
- Address arithmetic:
  - `RAMAdresse` wraps modulo 2^ADDR_WIDTH; 0xFFFF is followed by 0x0000.
  - `SDAdresse` wraps modulo 2^32.
- Reset mid-dump: return to IDLE on the next edge with `SDSchreiben` 0. Words already written stay on the card; there is no rollback.

## Timing
- Outputs are registered.
- `SDSchreiben` is high for exactly one cycle per word. `SDAdresse` and `SDDaten` are stable in that cycle.
- With `Start` in cycle 0 and `SDBusy` held 0:
  - header strobe in cycle 2;
  - data word k (k=1..N) strobe in cycle 2+5k;
  - `Fertig` in cycle 4+5N;
  - `Busy` high in cycles 1 through 4+5N.
- Each cycle with `SDBusy`=1 in KOPF, SDWARTEN or SCHREIBEN adds one cycle.
- N=0: `Fertig` in cycle 1; `Busy` stays 0.
- Throughput: at most one SD word per 5 cycles.

## Configuration
- `PRUEFSUMME_EN` defined:
  - the engine keeps a running sum, modulo 2^32, of all data words written;
  - after the last data word it writes the sum at `SDZielAdresse+N+1` through one extra SCHREIBEN/BLIND/SDWARTEN pass;
  - `Fertig` moves 3 cycles later;
  - N=0 still writes nothing.
- `PRUEFSUMME_EN` not defined: no sum register and no extra word; timing is as listed above.

## Test plan
- Basic dump: N=3, `StartAdresse`=0x0010, `SDZielAdresse`=0x100, RAM[0x10..0x12]=A,B,C, `SDBusy`=0 → SD writes (0x100,2), (0x101,A), (0x102,B), (0x103,C) at cycles 2/7/12/17; `Fertig` at cycle 19.
- Empty request: N=0 → no `SDSchreiben`; `Fertig` at cycle 1; `Busy` never high.
- SD stall: hold `SDBusy`=1 for 10 cycles after the header strobe → first data strobe moves from cycle 7 to cycle 17; no duplicate or missing strobes.
- Wrap and ignored restart: `StartAdresse`=0xFFFF, N=2 → RAM reads at 0xFFFF then 0x0000; a second `Start` at cycle 5 causes no extra writes.
- Reset mid-dump: N=4, `Reset` in cycle 9 → `SDSchreiben`=0 and `Busy`=0 from cycle 10; a fresh `Start` then runs correctly.
- `PRUEFSUMME_EN`: N=2 with data 0xFFFFFFFF and 0x00000002 → extra word 0x00000001 written at `SDZielAdresse+3`.

Source files
------------

// File: rtl/ram_sd_speicherer.sv
// RAM-to-SD dump engine: length header, then N RAM words to consecutive SD words.
// Define PRUEFSUMME_EN to append a modulo-2^32 sum of the data words.
module ram_sd_speicherer #(
    parameter int ADDR_WIDTH = 16,
    parameter int WORDSIZE   = 32
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] StartAdresse,
    input  logic [31:0]           Anzahl,
    input  logic [31:0]           SDZielAdresse,
    output logic [ADDR_WIDTH-1:0] RAMAdresse,
    input  logic [WORDSIZE-1:0]   RAMDatenRein,
    output logic [31:0]           SDAdresse,
    output logic [WORDSIZE-1:0]   SDDaten,
    output logic                  SDSchreiben,
    input  logic                  SDBusy,
    output logic                  Busy,
    output logic                  Fertig
);

    typedef enum logic [2:0] {
        IDLE,
        KOPF,
        BLIND,
        SDWARTEN,
        RAMLESEN,
        RAMDATEN,
        SCHREIBEN,
        ENDE
    } zustand_t;

    zustand_t              zustand, zustandN;
    logic [ADDR_WIDTH-1:0] ramAdrN;
    logic [31:0]           sdAdrN;
    logic [WORDSIZE-1:0]   sdDatN;
    logic                  sdWrN;
    logic                  busyN;
    logic                  fertigN;
    logic [31:0]           rest, restN;
    logic [31:0]           ziel, zielN;
`ifdef PRUEFSUMME_EN
    logic [WORDSIZE-1:0]   summe, summeN;
    logic                  summeDone, summeDoneN;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand     <= IDLE;
            RAMAdresse  <= '0;
            SDAdresse   <= '0;
            SDDaten     <= '0;
            SDSchreiben <= 1'b0;
            Busy        <= 1'b0;
            Fertig      <= 1'b0;
            rest        <= '0;
            ziel        <= '0;
`ifdef PRUEFSUMME_EN
            summe       <= '0;
            summeDone   <= 1'b0;
`endif
        end else begin
            zustand     <= zustandN;
            RAMAdresse  <= ramAdrN;
            SDAdresse   <= sdAdrN;
            SDDaten     <= sdDatN;
            SDSchreiben <= sdWrN;
            Busy        <= busyN;
            Fertig      <= fertigN;
            rest        <= restN;
            ziel        <= zielN;
`ifdef PRUEFSUMME_EN
            summe       <= summeN;
            summeDone   <= summeDoneN;
`endif
        end
    end

    always_comb begin
        zustandN = zustand;
        ramAdrN  = RAMAdresse;
        sdAdrN   = SDAdresse;
        sdDatN   = SDDaten;
        sdWrN    = 1'b0;
        fertigN  = 1'b0;
        restN    = rest;
        zielN    = ziel;
`ifdef PRUEFSUMME_EN
        summeN     = summe;
        summeDoneN = summeDone;
`endif
        unique case (zustand)
            IDLE: begin
                if (Start) begin
                    if (Anzahl != 32'd0) begin
                        zielN    = SDZielAdresse;
                        restN    = Anzahl;
                        ramAdrN  = StartAdresse;
                        zustandN = KOPF;
`ifdef PRUEFSUMME_EN
                        summeN     = '0;
                        summeDoneN = 1'b0;
`endif
                    end else begin
                        fertigN = 1'b1;
                    end
                end
            end
            KOPF: begin
                if (!SDBusy) begin
                    sdDatN   = WORDSIZE'(rest - 32'd1);
                    sdAdrN   = ziel;
                    sdWrN    = 1'b1;
                    zustandN = BLIND;
                end
            end
            // the writer raises SDBusy only one cycle after our strobe
            BLIND: zustandN = SDWARTEN;
            SDWARTEN: begin
                if (!SDBusy) begin
                    if (rest != 32'd0) begin
                        zustandN = RAMLESEN;
                    end else begin
`ifdef PRUEFSUMME_EN
                        if (!summeDone) begin
                            sdDatN     = summe;
                            summeDoneN = 1'b1;
                            zustandN   = SCHREIBEN;
                        end else begin
                            zustandN = ENDE;
                        end
`else
                        zustandN = ENDE;
`endif
                    end
                end
            end
            RAMLESEN: zustandN = RAMDATEN;
            RAMDATEN: begin
                sdDatN   = RAMDatenRein;
                zustandN = SCHREIBEN;
`ifdef PRUEFSUMME_EN
                summeN = summe + RAMDatenRein;
`endif
            end
            SCHREIBEN: begin
                if (!SDBusy) begin
                    sdWrN    = 1'b1;
                    sdAdrN   = SDAdresse + 32'd1;
                    zustandN = BLIND;
                    // rest is 0 only on the trailing sum word
                    if (rest != 32'd0) begin
                        ramAdrN = RAMAdresse + 1'b1;
                        restN   = rest - 32'd1;
                    end
                end
            end
            ENDE: zustandN = IDLE;
        endcase
        busyN   = (zustandN != IDLE);
        fertigN = fertigN | (zustandN == ENDE);
    end

endmodule
